// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - moka_rv32 instruction fetch: owns the PC, fetches one word at a time, hands it to decode.
// Redirects either retarget the PC or mark an outstanding fetch stale.
module ifetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  dec_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [DATA_WIDTH-1:0] instr_pc_plus4,
  output logic [6:0]            op,
  output logic [2:0]            funct3,
  output logic                  funct7
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  localparam logic [DATA_WIDTH-1:0] FOUR       = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] req_addr;
  logic                  drop;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] next_addr;

  // A redirect arriving in the same cycle a new fetch starts wins over the stored PC.
  assign target    = redirect_pc & ALIGN_MASK;
  assign next_addr = redirect ? target : pc;

  assign imem_addr      = req_addr;
  assign instr_pc_plus4 = instr_pc + FOUR;
  assign op             = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[30];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= '0;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      if (redirect) pc <= target;
      unique case (state)
        IDLE: begin
          if (en) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            req_addr <= next_addr;
          end
        end
        FETCH: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (drop || redirect) begin
              // Stale response: throw it away and either refetch or park.
              if (en) begin
                req_addr <= next_addr;
              end else begin
                state    <= IDLE;
                imem_req <= 1'b0;
              end
            end else begin
              state       <= VALID;
              imem_req    <= 1'b0;
              instr_valid <= 1'b1;
              instr       <= imem_rdata;
              instr_pc    <= req_addr;
              pc          <= req_addr + FOUR;
            end
          end else if (redirect) begin
            // The address must not move mid-handshake, so remember to discard instead.
            drop <= 1'b1;
          end
        end
        VALID: begin
          if (redirect || dec_ready) begin
            instr_valid <= 1'b0;
            if (en) begin
              state    <= FETCH;
              imem_req <= 1'b1;
              req_addr <= next_addr;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed table, reset/wrap sequences and randomized run against a program-order model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst, en, imem_rvalid, redirect, dec_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, instr_valid, funct7;
  logic [31:0] imem_addr, instr, instr_pc, instr_pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        w_req, w_valid, w_funct7;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic [6:0]  w_op;
  logic [2:0]  w_funct3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .en(en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_ready(dec_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .op(op), .funct3(funct3), .funct7(funct7)
  );

  ifetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_ready(dec_ready), .instr_valid(w_valid),
    .instr(w_instr), .instr_pc(w_pc), .instr_pc_plus4(w_pc4),
    .op(w_op), .funct3(w_funct3), .funct7(w_funct7)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic rv, input logic [31:0] rdat,
                       input logic rd, input logic [31:0] rpc, input logic dr);
    en = e; imem_rvalid = rv; imem_rdata = rdat;
    redirect = rd; redirect_pc = rpc; dec_ready = dr;
  endtask

  task automatic check_slices(input string tag, input logic [31:0] ei, input logic [31:0] epc);
    chk({tag, "_instr"}, instr, ei);
    chk({tag, "_instr_pc"}, instr_pc, epc);
    chk({tag, "_pc_plus4"}, instr_pc_plus4, epc + 32'd4);
    chk({tag, "_op"}, 32'(op), 32'(ei[6:0]));
    chk({tag, "_funct3"}, 32'(funct3), 32'(ei[14:12]));
    chk({tag, "_funct7"}, 32'(funct7), 32'(ei[30]));
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic        en, rv;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] rpc;
    logic        dr;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc, einstr;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic rv, input logic [31:0] rdat,
                              input logic rd, input logic [31:0] rpc, input logic dr,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evld, input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.en = e; v.rv = rv; v.rdata = rdat; v.rd = rd; v.rpc = rpc; v.dr = dr;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc; v.einstr = ei;
    return v;
  endfunction

  vec_t tbl[$];

  // Random-phase state
  logic [31:0] exp_pc;
  logic        p_req, p_rv, p_valid, p_dr, p_rd, p_en;
  logic [31:0] p_addr, p_instr, p_ipc;
  logic        busy;
  int          cnt;
  int          delivered;

  initial begin
    // Fill in the directed table: each row is inputs for a cycle plus outputs expected in that cycle.
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,  0,32'h0,  32'h0));
    tbl.push_back(mk(1,1,32'h00500093, 0,32'h0,  0, 1,32'h0,  0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,  1,32'h0,  32'h00500093));
    tbl.push_back(mk(1,1,32'h00A00113, 0,32'h0,  0, 1,32'h4,  0,32'h0,  32'h0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1,0,32'h0,      0,32'h0,  0, 0,32'h0,  1,32'h4,  32'h00A00113));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,  1,32'h4,  32'h00A00113));
    tbl.push_back(mk(1,0,32'h0,        1,32'h100,0, 1,32'h8,  0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  0, 1,32'h8,  0,32'h0,  32'h0));
    tbl.push_back(mk(1,1,32'hDEADBEEF, 0,32'h0,  0, 1,32'h8,  0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  0, 1,32'h100,0,32'h0,  32'h0));
    tbl.push_back(mk(1,1,32'h00000013, 0,32'h0,  0, 1,32'h100,0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,  1,32'h100,32'h00000013));
    tbl.push_back(mk(1,1,32'h00000BAD, 1,32'h203,0, 1,32'h104,0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  0, 1,32'h200,0,32'h0,  32'h0));
    tbl.push_back(mk(1,1,32'h00100073, 0,32'h0,  0, 1,32'h200,0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        1,32'h300,1, 0,32'h0,  1,32'h200,32'h00100073));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  0, 1,32'h300,0,32'h0,  32'h0));
    tbl.push_back(mk(0,1,32'h40000011, 0,32'h0,  0, 1,32'h300,0,32'h0,  32'h0));
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,  1, 0,32'h0,  1,32'h300,32'h40000011));
    tbl.push_back(mk(0,1,32'hFFFFFFFF, 0,32'h0,  0, 0,32'h0,  0,32'h0,  32'h0));
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,  0, 0,32'h0,  0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,  0,32'h0,  32'h0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,  0, 1,32'h304,0,32'h0,  32'h0));

    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus4", instr_pc_plus4, 32'h4);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_funct3", 32'(funct3), 32'h0);
    chk("rst_funct7", 32'(funct7), 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      vec_t t;
      string tag;
      t = tbl[i];
      tag = $sformatf("row%0d", i);
      drive(t.en, t.rv, t.rdata, t.rd, t.rpc, t.dr);
      chk({tag, "_req"}, 32'(imem_req), 32'(t.ereq));
      if (t.ereq) chk({tag, "_addr"}, imem_addr, t.eaddr);
      chk({tag, "_valid"}, 32'(instr_valid), 32'(t.evld));
      if (t.evld) check_slices(tag, t.einstr, t.epc);
      @(negedge clk);
    end

    // Reset while a fetch is outstanding, then a late response must be ignored.
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    rst = 1'b1;
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    chk("midrst_pc_plus4", instr_pc_plus4, 32'h4);
    rst = 1'b0;
    drive(0, 1, 32'h12345678, 0, 32'h0, 0);
    @(negedge clk);
    chk("late_rvalid_req", 32'(imem_req), 32'h0);
    chk("late_rvalid_valid", 32'(instr_valid), 32'h0);

    // Wrapping PC on the second instance.
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("wrap_req", 32'(w_req), 32'h1);
    chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
    drive(1, 1, 32'h00000013, 0, 32'h0, 0);
    @(negedge clk);
    chk("wrap_valid", 32'(w_valid), 32'h1);
    chk("wrap_instr_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", w_pc4, 32'h0);
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    chk("wrap_next_req", 32'(w_req), 32'h1);
    chk("wrap_next_addr", w_addr, 32'h0);

    // Randomized run: decode must see a program-order stream that restarts at each redirect target.
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    p_req = 0; p_rv = 0; p_valid = 0; p_dr = 0; p_rd = 0; p_en = 0;
    p_addr = 0; p_instr = 0; p_ipc = 0;
    busy = 0; cnt = 0; delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        r_en, r_rv, r_rd, r_dr;
      logic [31:0] r_rdata, r_rpc;
      if (p_req && !p_rv) begin
        chk("rnd_req_hold", 32'(imem_req), 32'h1);
        chk("rnd_addr_hold", imem_addr, p_addr);
      end
      if (imem_req && (!p_req || p_rv)) begin
        chk("rnd_start_needs_en", 32'(p_en), 32'h1);
        chk("rnd_fetch_addr", imem_addr, exp_pc);
      end
      if (instr_valid && !p_valid) begin
        chk("rnd_present_src", 32'(p_req && p_rv && !p_rd), 32'h1);
        check_slices("rnd_present", mem_word(exp_pc), exp_pc);
        delivered++;
      end
      if (p_valid && !p_rd && !p_dr) begin
        chk("rnd_hold_valid", 32'(instr_valid), 32'h1);
        chk("rnd_hold_instr", instr, p_instr);
        chk("rnd_hold_pc", instr_pc, p_ipc);
        chk("rnd_no_prefetch", 32'(imem_req), 32'h0);
      end
      if (p_valid && (p_rd || p_dr)) chk("rnd_retire", 32'(instr_valid), 32'h0);

      r_en = ($urandom_range(0, 7) != 0);
      r_dr = $urandom_range(0, 1) != 0;
      r_rd = ($urandom_range(0, 11) == 0);
      r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (imem_req) begin
        if (!busy) begin
          busy = 1;
          cnt = $urandom_range(0, 2);
        end
        r_rv = (cnt == 0);
        if (r_rv) busy = 0;
        else cnt--;
        r_rdata = r_rv ? mem_word(imem_addr) : $urandom;
      end else begin
        busy = 0;
        r_rv = ($urandom_range(0, 7) == 0);
        r_rdata = $urandom;
      end
      drive(r_en, r_rv, r_rdata, r_rd, r_rpc, r_dr);

      if (r_rd) exp_pc = r_rpc & 32'hFFFF_FFFC;
      else if (instr_valid && r_dr) exp_pc = exp_pc + 32'd4;

      p_req = imem_req; p_addr = imem_addr; p_rv = r_rv;
      p_valid = instr_valid; p_instr = instr; p_ipc = instr_pc;
      p_dr = r_dr; p_rd = r_rd; p_en = r_en;
      @(negedge clk);
    end
    chk("rnd_progress", 32'(delivered > 100), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
